picoblaze_io_ctrl: RTL and testbench
====================================

Name: picoblaze_io_ctrl

Overview:
- Parametrised I/O and interrupt controller between a PacoBlaze3 core and board logic.
- Generalises the single-port, single-interrupt glue:
  - NUM_IN data inputs, each with optional absolute-value conversion.
  - NUM_OUT read-back output registers.
  - NUM_EVT edge-detected event sources with pending/mask registers.
  - An interrupt request FSM with a post-acknowledge hold-off.
- Sits beside the core; all core-side signals are synchronous to clk.

Parameters:
- DATA_W, 8: width of data inputs, out_port/in_port path and output registers. Must be 8 for the PacoBlaze bus.
- NUM_IN, 4: number of data input channels (1..16).
- NUM_OUT, 2: number of output registers (1..16).
- NUM_EVT, 4: number of event sources (1..8).
- ABS_MASK, 4'b0001: bit k=1 means input k is returned as its absolute value.
- HOLDOFF_CYC, 16: clk cycles the interrupt stays low after interrupt_ack (minimum 1).

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- port_id, input, 8: core port address.
- write_strobe, input, 1: core write qualifier.
- read_strobe, input, 1: core read qualifier (informational; reads have no side effects).
- out_port, input, 8: core write data.
- in_port, output, 8: registered read data to core.
- interrupt, output, 1: interrupt request to core.
- interrupt_ack, input, 1: core acknowledge, 1-cycle pulse, sampled on clk.
- input_data, input, NUM_IN*DATA_W: channel k occupies [k*8+7:k*8], two's complement.
- event_in, input, NUM_EVT: event sources, synchronous to clk.
- out_data, output, NUM_OUT*DATA_W: output registers, channel k at [k*8+7:k*8].

Behaviour:
- Reset (reset_n=0, asynchronous) clears: in_port=0, interrupt=0, out_data=0, pending=0, mask=0, event history=0. FSM goes to IDLE and the hold-off counter to 0.
- Port map, fully decoded:
  - 0x00+k (k<NUM_IN), read: input k.
  - 0x10, read: pending register (zero-extended).
  - 0x11, read/write: mask register.
  - 0x12, write: pending clear, write-1-to-clear.
  - 0x13, read: {pending_any, 4'b0, lowest-index pending&mask bit}. Returns 0x00 when none.
  - 0x80+k (k<NUM_OUT), read/write: output register k.
  - Any other read returns 0x00. Any other write is ignored.
- Read path: in_port is registered from the port_id value one clk cycle earlier (1-cycle latency), every cycle, independent of read_strobe.
- Absolute-value rule (channels with ABS_MASK bit set):
  - Negative input: return its two's-complement negation.
  - 0x80 (-128) saturates to 0x7F.
  - Other channels pass through unchanged.
- Write path: register updates on the clk edge where write_strobe=1. Takes effect on the next cycle, both at out_data and on readback.
- Event detection:
  - prev[i] holds event_in[i] from the previous cycle.
  - Rising edge (event_in & ~prev) sets pending[i].
  - A level held high sets pending only once.
- Simultaneous set and clear on the same pending bit in one cycle: set wins (bit stays 1).
- Mask gates the interrupt only. Unmasked-off events still latch into pending.
- Interrupt FSM:
  - IDLE: interrupt=0. If |(pending & mask), go to REQ.
  - REQ: interrupt=1, held until interrupt_ack=1. Then go to HOLD and load the counter with HOLDOFF_CYC-1.
  - HOLD: interrupt=0. Counter decrements each cycle; at 0, go to IDLE.
  - IDLE re-evaluates the same cycle it is entered, so still-pending causes REQ on the next cycle.
- interrupt_ack outside REQ is ignored.
- If pending&mask drops to 0 while in REQ (cleared by software), return to IDLE with interrupt=0 on the next cycle. A late ack is ignored.
- interrupt is a registered output (FSM state decode from a flop). No combinational path from event_in to interrupt.
- Reset mid-request: interrupt drops immediately (async). Pending events are lost.

Test Plan:
- Reset: hold reset_n=0, drive event_in=4'hF and input_data nonzero. Required: interrupt=0, out_data=0, in_port=0. After release, pending reads 0x0F only after edges that occur post-reset.
- Abs/readback:
  - input ch0=0xF6: read 0x00 returns 0x0A one cycle later.
  - ch0=0x80 returns 0x7F.
  - ch1=0xF6 (no abs) returns 0xF6.
  - Write 0x5A to 0x81: out_data[15:8]=0x5A, read 0x81 returns 0x5A.
- Interrupt flow:
  - Set mask=0x02, pulse event_in[1]: interrupt=1 two cycles after the edge.
  - Pulse interrupt_ack: interrupt=0 for exactly 16 cycles.
  - If pending is not cleared, interrupt re-asserts.
  - Write 0x02 to 0x12 during HOLD: interrupt stays 0.
- Masking and priority:
  - Events on bits 0 and 3 with mask=0x08: pending=0x09, read 0x13 returns 0x83.
  - With mask=0x00: interrupt stays 0.
- Set/clear collision: rising edge on event 2 in the same cycle as write 0x04 to 0x12 -> pending[2]=1.
- Software cancel: in REQ, clear the only pending bit -> interrupt=0 next cycle. A following ack pulse causes no HOLD (a new event asserts within 2 cycles).

Source files
------------

// File: rtl/picoblaze_io_ctrl.sv
// PacoBlaze3 I/O and interrupt controller: input channels with optional absolute value,
// read-back output registers, edge-detected events and an interrupt FSM with post-ack hold-off.
module picoblaze_io_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                NUM_IN      = 4,
    parameter int                NUM_OUT     = 2,
    parameter int                NUM_EVT     = 4,
    parameter logic [NUM_IN-1:0] ABS_MASK    = 4'b0001,
    parameter int                HOLDOFF_CYC = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 port_id,
    input  logic                       write_strobe,
    input  logic                       read_strobe,
    input  logic [DATA_W-1:0]          out_port,
    output logic [DATA_W-1:0]          in_port,
    output logic                       interrupt,
    input  logic                       interrupt_ack,
    input  logic [NUM_IN*DATA_W-1:0]   input_data,
    input  logic [NUM_EVT-1:0]         event_in,
    output logic [NUM_OUT*DATA_W-1:0]  out_data
);

    localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

    localparam logic [7:0] ADDR_PEND   = 8'h10;
    localparam logic [7:0] ADDR_MASK   = 8'h11;
    localparam logic [7:0] ADDR_CLR    = 8'h12;
    localparam logic [7:0] ADDR_STATUS = 8'h13;
    localparam logic [7:0] ADDR_OUT    = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [CNT_W-1:0]            cnt_next_s;
    logic                        interrupt_r;
    logic [DATA_W-1:0]           in_port_r;
    logic [DATA_W-1:0]           rd_data_s;
    logic [NUM_OUT*DATA_W-1:0]   out_data_r;
    logic [NUM_EVT-1:0]          mask_r;
    logic [NUM_EVT-1:0]          pending_r;
    logic [NUM_EVT-1:0]          prev_r;
    logic [NUM_EVT-1:0]          rise_s;
    logic [NUM_EVT-1:0]          clr_s;
    logic [NUM_EVT-1:0]          pm_s;
    logic [7:0]                  status_s;
    logic [DATA_W-1:0]           chan_s [NUM_IN];
    logic                        unused_s;

    // Absolute value with -128 saturating to +127 so the result stays representable.
    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (v[DATA_W-1]) begin
            r = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [NUM_EVT-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            r = v[i] ? 3'(i) : r;
        end
        return r;
    endfunction

    assign unused_s = read_strobe;
    assign rise_s   = event_in & ~prev_r;
    assign clr_s    = (write_strobe && (port_id == ADDR_CLR)) ? out_port[NUM_EVT-1:0]
                                                              : {NUM_EVT{1'b0}};
    assign pm_s     = pending_r & mask_r;
    assign status_s = {|pm_s, 4'b0000, lowest_idx(pm_s)};

    // Per-channel input conditioning.
    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (ABS_MASK[k]) begin
                chan_s[k] = abs_sat(input_data[k*DATA_W +: DATA_W]);
            end else begin
                chan_s[k] = input_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Fully decoded read mux; unmapped addresses read as zero.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        case (port_id)
            ADDR_PEND:   rd_data_s = DATA_W'(pending_r);
            ADDR_MASK:   rd_data_s = DATA_W'(mask_r);
            ADDR_STATUS: rd_data_s = status_s;
            default: begin
                for (int k = 0; k < NUM_IN; k++) begin
                    rd_data_s = (port_id == 8'(k)) ? chan_s[k] : rd_data_s;
                end
                for (int k = 0; k < NUM_OUT; k++) begin
                    rd_data_s = (port_id == (ADDR_OUT + 8'(k))) ? out_data_r[k*DATA_W +: DATA_W]
                                                                : rd_data_s;
                end
            end
        endcase
    end

    // Registered read data, updated every cycle regardless of read_strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_port_r <= {DATA_W{1'b0}};
        end else begin
            in_port_r <= rd_data_s;
        end
    end

    // Software-writable mask and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r     <= {NUM_EVT{1'b0}};
            out_data_r <= {(NUM_OUT*DATA_W){1'b0}};
        end else if (write_strobe) begin
            if (port_id == ADDR_MASK) begin
                mask_r <= out_port[NUM_EVT-1:0];
            end
            for (int k = 0; k < NUM_OUT; k++) begin
                if (port_id == (ADDR_OUT + 8'(k))) begin
                    out_data_r[k*DATA_W +: DATA_W] <= out_port;
                end
            end
        end
    end

    // Edge history and pending latch; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r    <= {NUM_EVT{1'b0}};
            pending_r <= {NUM_EVT{1'b0}};
        end else begin
            prev_r    <= event_in;
            pending_r <= (pending_r & ~clr_s) | rise_s;
        end
    end

    // Interrupt FSM next-state; leaving HOLD re-evaluates as IDLE would.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|pm_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!(|pm_s)) begin
                    state_next_s = ST_IDLE;
                end else if (interrupt_ack) begin
                    state_next_s = ST_HOLD;
                    cnt_next_s   = CNT_W'(HOLDOFF_CYC - 1);
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = (|pm_s) ? ST_REQ : ST_IDLE;
                end else begin
                    cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, hold-off counter and registered interrupt decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            interrupt_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            interrupt_r <= (state_next_s == ST_REQ);
        end
    end

    assign in_port   = in_port_r;
    assign interrupt = interrupt_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_picoblaze_io_ctrl.sv
// Self-checking bench for picoblaze_io_ctrl: table-driven readback through a
// scoreboard queue plus hand-written interrupt sequences.
module tb_picoblaze_io_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  port_id;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  out_port;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack;
    logic [31:0] input_data;
    logic [3:0]  event_in;
    logic [15:0] out_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] din;
        logic [7:0]  addr;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[12];

    picoblaze_io_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .input_data    (input_data),
        .event_in      (event_in),
        .out_data      (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and retire one pending read expectation.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, {24'h0, in_port}, {24'h0, e.exp});
        end
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
        sb_t e;
        port_id     = addr;
        read_strobe = 1'b1;
        e.exp       = exp;
        e.name      = name;
        sb_q.push_back(e);
        tick();
        read_strobe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'hFF;
    endtask

    task automatic wait_irq(input logic lvl, input int max_cyc, input string name);
        int n;
        n = 0;
        while (interrupt !== lvl && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, {31'h0, interrupt}, {31'h0, lvl});
    endtask

    initial begin
        int low;
        int got;
        int highs;

        vecs[0]  = '{32'h000000F6, 8'h00, 8'h0A};
        vecs[1]  = '{32'h00000080, 8'h00, 8'h7F};
        vecs[2]  = '{32'h0000007F, 8'h00, 8'h7F};
        vecs[3]  = '{32'h000000FF, 8'h00, 8'h01};
        vecs[4]  = '{32'h00000000, 8'h00, 8'h00};
        vecs[5]  = '{32'h0000F600, 8'h01, 8'hF6};
        vecs[6]  = '{32'h00800000, 8'h02, 8'h80};
        vecs[7]  = '{32'h80000000, 8'h03, 8'h80};
        vecs[8]  = '{32'h12345678, 8'h04, 8'h00};
        vecs[9]  = '{32'h12345678, 8'h20, 8'h00};
        vecs[10] = '{32'h12345678, 8'h82, 8'h00};
        vecs[11] = '{32'h12345678, 8'h12, 8'h00};

        reset_n       = 1'b0;
        port_id       = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        out_port      = 8'h00;
        interrupt_ack = 1'b0;
        input_data    = 32'h80F6F6F6;
        event_in      = 4'hF;

        // Reset state with active inputs.
        tick();
        tick();
        check("rst_interrupt", {31'h0, interrupt}, 32'h0);
        check("rst_out_data", {16'h0, out_data}, 32'h0);
        check("rst_in_port", {24'h0, in_port}, 32'h0);
        event_in = 4'h0;
        tick();
        reset_n = 1'b1;
        rd(8'h10, 8'h00, "pend_after_reset");
        event_in = 4'hF;
        tick();
        event_in = 4'h0;
        rd(8'h10, 8'h0F, "pend_post_reset_edges");
        wr(8'h12, 8'h0F);
        rd(8'h10, 8'h00, "pend_cleared");

        // Table-driven input readback.
        for (int i = 0; i < 12; i++) begin
            input_data = vecs[i].din;
            rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_addr%0h", i, vecs[i].addr));
        end

        // Output registers.
        wr(8'h80, 8'hA5);
        wr(8'h81, 8'h5A);
        check("out_data_written", {16'h0, out_data}, 32'h5AA5);
        wr(8'h82, 8'h33);
        check("out_data_unmapped_write", {16'h0, out_data}, 32'h5AA5);
        rd(8'h81, 8'h5A, "rd_out1");
        rd(8'h80, 8'hA5, "rd_out0");

        // Interrupt request, hold-off and re-assertion.
        wr(8'h11, 8'h02);
        rd(8'h11, 8'h02, "rd_mask");
        event_in = 4'b0010;
        tick();
        event_in = 4'b0000;
        check("irq_one_cycle_after_edge", {31'h0, interrupt}, 32'h0);
        tick();
        check("irq_two_cycles_after_edge", {31'h0, interrupt}, 32'h1);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        low = 0;
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            if (interrupt === 1'b0) begin
                low++;
                tick();
            end else begin
                got = 1;
            end
        end
        check("holdoff_len", low, 32'd16);
        check("irq_reassert", got, 32'd1);

        // Clearing pending during hold-off keeps the request away.
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        tick();
        wr(8'h12, 8'h02);
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (interrupt !== 1'b0) highs++;
        end
        check("no_irq_after_hold_clear", highs, 32'd0);
        rd(8'h10, 8'h00, "pend_after_hold_clear");

        // Masking and lowest-index status.
        wr(8'h11, 8'h08);
        event_in = 4'b1001;
        tick();
        event_in = 4'b0000;
        rd(8'h10, 8'h09, "pend_0_3");
        rd(8'h13, 8'h83, "status_idx3");
        check("irq_masked_bit3", {31'h0, interrupt}, 32'h1);
        wr(8'h12, 8'h09);
        tick();
        tick();
        check("irq_drop_after_clear", {31'h0, interrupt}, 32'h0);
        wr(8'h11, 8'h00);
        event_in = 4'hF;
        tick();
        event_in = 4'h0;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (interrupt !== 1'b0) highs++;
        end
        check("mask_zero_no_irq", highs, 32'd0);
        rd(8'h13, 8'h00, "status_none");
        rd(8'h10, 8'h0F, "pend_latched_unmasked");
        wr(8'h12, 8'h0F);

        // Set beats clear in the same cycle.
        event_in = 4'b0100;
        wr(8'h12, 8'h04);
        event_in = 4'b0000;
        rd(8'h10, 8'h04, "set_wins_clear");
        wr(8'h12, 8'h04);
        rd(8'h10, 8'h00, "plain_clear");

        // Software cancel in REQ, then a late ack must not start a hold-off.
        wr(8'h11, 8'h04);
        event_in = 4'b0100;
        tick();
        event_in = 4'b0000;
        wait_irq(1'b1, 4, "cancel_setup_irq");
        wr(8'h12, 8'h04);
        tick();
        check("cancel_irq_drop", {31'h0, interrupt}, 32'h0);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        event_in = 4'b0100;
        tick();
        event_in = 4'b0000;
        tick();
        check("late_ack_no_hold", {31'h0, interrupt}, 32'h1);

        // Asynchronous reset in the middle of a request.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {31'h0, interrupt}, 32'h0);
        check("async_rst_out", {16'h0, out_data}, 32'h0);
        tick();
        reset_n = 1'b1;
        rd(8'h10, 8'h00, "pend_lost_on_reset");
        rd(8'h11, 8'h00, "mask_reset");
        tick();
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
